// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32 memory path.
// Contents:
//   - memop encodings used by loads and stores
//   - MemType region codes for the memory-map decode
//   - helpers for lane masks and access legality
package rv_mem_pkg;

   localparam logic [2:0] MEMOP_W  = 3'b000;
   localparam logic [2:0] MEMOP_HS = 3'b001;
   localparam logic [2:0] MEMOP_BS = 3'b010;
   localparam logic [2:0] MEMOP_HU = 3'b101;
   localparam logic [2:0] MEMOP_BU = 3'b110;

   typedef enum logic [1:0] {
      MEMTYPE_NONE = 2'd0,
      MEMTYPE_INST = 2'd1,
      MEMTYPE_DATA = 2'd2,
      MEMTYPE_MMIO = 2'd3
   } mem_type_e;

   // Lanes touched by an access; empty for misaligned or invalid accesses.
   function automatic logic [3:0] lane_mask(input logic [2:0] memop, input logic [1:0] off);
      logic [3:0] mask;
      case (memop)
         MEMOP_W:            mask = (off == 2'b00) ? 4'b1111 : 4'b0000;
         MEMOP_HS, MEMOP_HU: mask = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
         MEMOP_BS, MEMOP_BU: mask = 4'b0001 << off;
         default:            mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // True when the access is misaligned for its width or the memop is invalid.
   function automatic logic access_bad(input logic [2:0] memop, input logic [1:0] off);
      logic bad;
      case (memop)
         MEMOP_W:            bad = (off != 2'b00);
         MEMOP_HS, MEMOP_HU: bad = off[0];
         MEMOP_BS, MEMOP_BU: bad = 1'b0;
         default:            bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/rv_dmem_load_align.sv
// Load alignment and extension for a 32-bit little-endian word.
// Ports:
//   word_i    raw 32-bit word read from storage
//   off_i     byte offset addr[1:0]; misaligned accesses are aligned down
//   memop_i   access type
//   data_o    extracted, sign/zero-extended result (0 for invalid memop)
//   invalid_o memop is not a legal load encoding
module rv_dmem_load_align
   import rv_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  memop_i,
   output logic [31:0] data_o,
   output logic        invalid_o
);

   logic [15:0] half_s;
   logic [7:0]  byte_s;

   // Lane selection: half uses addr[1] only, so a misaligned half reads its aligned-down lane pair.
   always_comb begin
      half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
      case (off_i)
         2'd0:    byte_s = word_i[7:0];
         2'd1:    byte_s = word_i[15:8];
         2'd2:    byte_s = word_i[23:16];
         2'd3:    byte_s = word_i[31:24];
         default: byte_s = 8'h00;
      endcase
   end

   // Extension per memop.
   always_comb begin
      data_o    = 32'h0000_0000;
      invalid_o = 1'b0;
      case (memop_i)
         MEMOP_W:  data_o = word_i;
         MEMOP_HS: data_o = {{16{half_s[15]}}, half_s};
         MEMOP_HU: data_o = {16'h0000, half_s};
         MEMOP_BS: data_o = {{24{byte_s[7]}}, byte_s};
         MEMOP_BU: data_o = {24'h00_0000, byte_s};
         default: begin
            data_o    = 32'h0000_0000;
            invalid_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/rv_dmem_unit.sv
// Byte-addressable little-endian RV32 data memory, single clock.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low; clears dataout/misalign only
//   addr      byte address; [WORD_ADDR_W+1:2] word, [1:0] lane, upper bits ignored
//   datain    store data (low byte/half used for narrow stores)
//   we        1 = store, 0 = load
//   memop     access type (rv_mem_pkg MEMOP_*)
//   dataout   registered load result, held on store cycles
//   misalign  registered: last access misaligned or invalid memop
module rv_dmem_unit
   import rv_mem_pkg::*;
#(
   parameter int    WORD_ADDR_W = 15,
   parameter string INIT_FILE   = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        we,
   input  logic [2:0]  memop,
   output logic [31:0] dataout,
   output logic        misalign
);

   localparam int DEPTH = 2 ** WORD_ADDR_W;

   logic [31:0]            mem_q [DEPTH];
   logic [WORD_ADDR_W-1:0] word_idx_s;
   logic [1:0]             lane_s;
   logic [3:0]             wmask_s;
   logic [31:0]            wdata_s;
   logic [31:0]            rd_word_s;
   logic [31:0]            ld_data_s;
   logic                   ld_invalid_s;
   logic [31:0]            dataout_d, dataout_q;
   logic                   misalign_d, misalign_q;
   logic                   unused_addr_s;

   assign word_idx_s    = addr[WORD_ADDR_W+1:2];
   assign lane_s        = addr[1:0];
   // Upper address bits are deliberately dropped so accesses wrap.
   assign unused_addr_s = ^addr[31:WORD_ADDR_W+2];

   // Store lane enables and replicated write data; the mask selects which copy lands.
   always_comb begin
      wmask_s = we ? lane_mask(memop, lane_s) : 4'b0000;
      case (memop)
         MEMOP_HS, MEMOP_HU: wdata_s = {2{datain[15:0]}};
         MEMOP_BS, MEMOP_BU: wdata_s = {4{datain[7:0]}};
         default:            wdata_s = datain;
      endcase
   end

   // Byte-enabled array write; gated off while reset is asserted.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask_s[i]) begin
               mem_q[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
         end
      end
   end

   assign rd_word_s = mem_q[word_idx_s];

   rv_dmem_load_align u_align (
      .word_i    (rd_word_s),
      .off_i     (lane_s),
      .memop_i   (memop),
      .data_o    (ld_data_s),
      .invalid_o (ld_invalid_s)
   );

   // Next-state for the output registers; stores hold dataout.
   always_comb begin
      misalign_d = access_bad(memop, lane_s);
      if (we) begin
         dataout_d = dataout_q;
      end else begin
         dataout_d = ld_invalid_s ? 32'h0000_0000 : ld_data_s;
      end
   end

   // Output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dataout_q  <= 32'h0000_0000;
         misalign_q <= 1'b0;
      end else begin
         dataout_q  <= dataout_d;
         misalign_q <= misalign_d;
      end
   end

   assign dataout  = dataout_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_rv_dmem_unit.sv
module tb_rv_dmem_unit;

   localparam logic [2:0] OP_W  = 3'b000;
   localparam logic [2:0] OP_HS = 3'b001;
   localparam logic [2:0] OP_BS = 3'b010;
   localparam logic [2:0] OP_HU = 3'b101;
   localparam logic [2:0] OP_BU = 3'b110;
   localparam logic [2:0] OP_X3 = 3'b011;
   localparam logic [2:0] OP_X4 = 3'b100;
   localparam logic [2:0] OP_X7 = 3'b111;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] datain;
   logic        we;
   logic [2:0]  memop;
   logic [31:0] dataout;
   logic        misalign;

   int          total = 0;
   int          bad   = 0;
   bit          pending = 1'b0;
   logic [31:0] exp_dout = 32'h0;
   logic        exp_mis  = 1'b0;
   bit   [7:0]  mm [int];

   always #5 clock = ~clock;

   rv_dmem_unit #(.WORD_ADDR_W(15), .INIT_FILE("")) dut (
      .clock    (clock),
      .reset    (reset),
      .addr     (addr),
      .datain   (datain),
      .we       (we),
      .memop    (memop),
      .dataout  (dataout),
      .misalign (misalign)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int width_of(input logic [2:0] op);
      case (op)
         OP_W:         return 4;
         OP_HS, OP_HU: return 2;
         OP_BS, OP_BU: return 1;
         default:      return 0;
      endcase
   endfunction

   // Reference model: byte-addressed memory over a 128 KiB window.
   task automatic model_step(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] op);
      int          wd;
      int          ba;
      int          base;
      bit          bad_acc;
      logic [31:0] v;
      wd      = width_of(op);
      ba      = int'(a & 32'h0001_FFFF);
      bad_acc = (wd == 0) ? 1'b1 : ((ba % wd) != 0);
      exp_mis = bad_acc;
      if (w) begin
         if (!bad_acc) begin
            for (int i = 0; i < wd; i++) mm[ba + i] = d[8*i +: 8];
         end
      end else if (wd == 0) begin
         exp_dout = 32'h0;
      end else begin
         base = ba - (ba % wd);
         v    = 32'h0;
         for (int i = 0; i < wd; i++) v[8*i +: 8] = mm.exists(base + i) ? mm[base + i] : 8'h00;
         if (op[2] == 1'b0 && wd < 4 && v[8*wd - 1]) v = v | (32'hFFFF_FFFF << (8*wd));
         exp_dout = v;
      end
   endtask

   task automatic op(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] o);
      @(negedge clock);
      we     = w;
      addr   = a;
      datain = d;
      memop  = o;
      model_step(w, a, d, o);
      pending = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // Compare process: every modelled edge is checked against the model.
   always @(posedge clock) begin
      #1;
      if (pending) begin
         check32("dataout", dataout, exp_dout);
         check32("misalign", {31'b0, misalign}, {31'b0, exp_mis});
         pending = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset  = 1'b0;
      we     = 1'b0;
      addr   = 32'h0;
      datain = 32'h0;
      memop  = OP_W;
      #2;
      check32("reset_dataout", dataout, 32'h0);
      check32("reset_misalign", {31'b0, misalign}, 32'h0);
      #6 reset = 1'b1;

      // Reset mid-operation, array preserved
      op(1'b1, 32'h40, 32'h1234_5678, OP_W);
      op(1'b0, 32'h40, 32'h0, OP_W);
      check32("lw_pre_reset", dataout, 32'h1234_5678);
      #1 reset = 1'b0;
      #1;
      check32("async_reset_dataout", dataout, 32'h0);
      check32("async_reset_misalign", {31'b0, misalign}, 32'h0);
      exp_dout = 32'h0;
      exp_mis  = 1'b0;
      #1 reset = 1'b1;
      op(1'b0, 32'h40, 32'h0, OP_W);
      check32("lw_post_reset", dataout, 32'h1234_5678);

      // Word then sub-word loads
      op(1'b1, 32'h10, 32'h8765_43A1, OP_W);
      op(1'b0, 32'h10, 32'h0, OP_BS);
      check32("lb_10", dataout, 32'hFFFF_FFA1);
      op(1'b0, 32'h10, 32'h0, OP_BU);
      check32("lbu_10", dataout, 32'h0000_00A1);
      op(1'b0, 32'h12, 32'h0, OP_HS);
      check32("lh_12", dataout, 32'hFFFF_8765);
      op(1'b0, 32'h12, 32'h0, OP_HU);
      check32("lhu_12", dataout, 32'h0000_8765);
      op(1'b0, 32'h13, 32'h0, OP_BS);
      check32("lb_13", dataout, 32'hFFFF_FF87);
      check32("lb_13_misalign", {31'b0, misalign}, 32'h0);

      // Narrow stores keep neighbouring lanes
      op(1'b1, 32'h11, 32'hFFFF_FF5A, OP_BS);
      op(1'b1, 32'h12, 32'h0000_BEEF, OP_HS);
      op(1'b0, 32'h10, 32'h0, OP_W);
      check32("lw_merge", dataout, 32'hBEEF_5AA1);

      // Misalignment
      op(1'b0, 32'h13, 32'h0, OP_W);
      check32("lw_13", dataout, 32'hBEEF_5AA1);
      check32("lw_13_misalign", {31'b0, misalign}, 32'h1);
      op(1'b1, 32'h11, 32'h0000_CAFE, OP_HS);
      check32("sh_11_misalign", {31'b0, misalign}, 32'h1);
      op(1'b0, 32'h10, 32'h0, OP_W);
      check32("lw_after_bad_sh", dataout, 32'hBEEF_5AA1);
      op(1'b0, 32'h11, 32'h0, OP_HU);
      op(1'b1, 32'h12, 32'hFFFF_FFFF, OP_W);
      op(1'b0, 32'h10, 32'h0, OP_W);

      // Invalid memops and address wrap
      op(1'b0, 32'h10, 32'h0, OP_X3);
      check32("inv_load", dataout, 32'h0);
      check32("inv_load_misalign", {31'b0, misalign}, 32'h1);
      op(1'b1, 32'h10, 32'hDEAD_BEEF, OP_X3);
      op(1'b0, 32'h10, 32'h0, OP_W);
      check32("lw_after_inv_store", dataout, 32'hBEEF_5AA1);
      op(1'b0, 32'h12, 32'h0, OP_X4);
      op(1'b0, 32'h10, 32'h0, OP_X7);
      op(1'b1, 32'h0002_0010, 32'hA5A5_A5A5, OP_W);
      op(1'b0, 32'h10, 32'h0, OP_W);
      check32("lw_wrap", dataout, 32'hA5A5_A5A5);

      // Back-to-back store/load and streaming loads
      op(1'b1, 32'h14, 32'h0BAD_F00D, OP_W);
      op(1'b0, 32'h14, 32'h0, OP_W);
      check32("raw_next", dataout, 32'h0BAD_F00D);
      op(1'b1, 32'h18, 32'h2222_2222, OP_W);
      op(1'b0, 32'h10, 32'h0, OP_W);
      check32("stream_10", dataout, 32'hA5A5_A5A5);
      op(1'b0, 32'h14, 32'h0, OP_W);
      check32("stream_14", dataout, 32'h0BAD_F00D);
      op(1'b0, 32'h18, 32'h0, OP_W);
      check32("stream_18", dataout, 32'h2222_2222);
      op(1'b1, 32'h1B, 32'h0000_0080, OP_BU);
      op(1'b0, 32'h1A, 32'h0, OP_HS);
      op(1'b0, 32'h18, 32'h0, OP_BS);

      @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
